// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock, result after 33 edges.
// Define DIV_SIGNED_EN for two's-complement operands; the default build is unsigned.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             busy,
    output logic [WIDTH-1:0] data_quotient,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic [1:0]       dbg_state
);

    // Handshake: start is taken only in IDLE; data_resultRDY is a single-cycle
    // pulse during which quotient/remainder/exception are valid (they also hold afterwards).

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CW-1:0]     count;
    logic [WIDTH-1:0]  quo_sh;
    logic [WIDTH-1:0]  divisor;
    logic [WIDTH:0]    rem;
    logic              div_zero;

    logic [WIDTH-1:0]  mag_a;
    logic [WIDTH-1:0]  mag_b;
    logic [WIDTH-1:0]  fin_q;
    logic [WIDTH-1:0]  fin_r;
    logic              fin_exc;

    logic [WIDTH:0]    rem_sh;
    logic [WIDTH:0]    trial;

    assign dbg_state = state;

    // One restoring step: bring in the next dividend bit, try subtracting the divisor.
    assign rem_sh = {rem[WIDTH-1:0], quo_sh[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, divisor};

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;
    logic ovf;

    assign mag_a   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign mag_b   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign fin_q   = neg_q ? -quo_sh : quo_sh;
    assign fin_r   = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    assign fin_exc = div_zero | ovf;
`else
    assign mag_a   = data_operandA;
    assign mag_b   = data_operandB;
    assign fin_q   = quo_sh;
    assign fin_r   = rem[WIDTH-1:0];
    assign fin_exc = div_zero;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= IDLE;
            count          <= '0;
            quo_sh         <= '0;
            divisor        <= '0;
            rem            <= '0;
            div_zero       <= 1'b0;
            busy           <= 1'b0;
            data_quotient  <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
            ovf            <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    data_resultRDY <= 1'b0;
                    if (start) begin
                        // A zero divisor preloads the final answer so the first RUN cycle just publishes it.
                        div_zero <= (data_operandB == '0);
                        quo_sh   <= (data_operandB == '0) ? '0 : mag_a;
                        rem      <= (data_operandB == '0) ? {1'b0, mag_a} : '0;
                        divisor  <= mag_b;
                        count    <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
`ifdef DIV_SIGNED_EN
                        neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        neg_r    <= data_operandA[WIDTH-1];
                        ovf      <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                    (data_operandB == {WIDTH{1'b1}});
`endif
                    end
                end

                RUN: begin
                    // The cycle after the last step applies the sign fix-up and publishes.
                    if (div_zero || count == CW'(WIDTH)) begin
                        data_quotient  <= fin_q;
                        data_remainder <= fin_r;
                        data_exception <= fin_exc;
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        state          <= DONE;
                    end else begin
                        rem    <= trial[WIDTH] ? rem_sh : trial;
                        quo_sh <= {quo_sh[WIDTH-2:0], ~trial[WIDTH]};
                        count  <= count + CW'(1);
                    end
                end

                DONE: begin
                    data_resultRDY <= 1'b0;
                    state          <= IDLE;
                end

                default: begin
                    state          <= IDLE;
                    busy           <= 1'b0;
                    data_resultRDY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random operands
// compared against an arithmetic reference model (signed when DIV_SIGNED_EN is defined).
module tb_seq_divider;

    localparam int WIDTH = 32;
    localparam int SW    = 2 * WIDTH + 1;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic [WIDTH-1:0] data_quotient;
    logic [WIDTH-1:0] data_remainder;
    logic             data_exception;
    logic             data_resultRDY;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [SW-1:0]    exp_q[$];
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_r;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .data_operandA  (a),
        .data_operandB  (b),
        .busy           (busy),
        .data_quotient  (data_quotient),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic division, packed as {quotient, remainder, exception}.
    function automatic logic [SW-1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             e;
        if (y == 0) begin
            q = 0; r = x; e = 1'b1;
        end
`ifdef DIV_SIGNED_EN
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 0; e = 1'b1;
        end else begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
            e = 1'b0;
        end
`else
        else begin
            q = x / y; r = x % y; e = 1'b0;
        end
`endif
        return {q, r, e};
    endfunction

    // ---------------- driver ----------------
    // Issues one division; optionally pokes a second start (50/5) before edge inject_at.
    task automatic run_div(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input int inject_at);
        logic [SW-1:0] e;
        int            lat;
        int            exp_lat;
        bit            busy_ok;
        exp_q.push_back(model(x, y));
        exp_lat = (y == 0) ? 1 : 33;
        start = 1'b1;
        a     = x;
        b     = y;
        @(posedge clock); #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        check("busy_after_accept", {63'd0, busy}, 64'd1);
        lat     = 0;
        busy_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (i == inject_at) begin
                start = 1'b1; a = 50; b = 5;
            end
            @(posedge clock); #1;
            if (i == inject_at) start = 1'b0;
            if (data_resultRDY) begin
                lat = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (i == 3) check("hold_q_during_run", {32'd0, data_quotient}, {32'd0, prev_q});
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("busy_while_running", {63'd0, busy_ok}, 64'd1);
        check("busy_in_done", {63'd0, busy}, 64'd0);
        e = exp_q.pop_front();
        check("quotient", {32'd0, data_quotient}, {32'd0, e[SW-1:WIDTH+1]});
        check("remainder", {32'd0, data_remainder}, {32'd0, e[WIDTH:1]});
        check("exception", {63'd0, data_exception}, {63'd0, e[0]});
        prev_q = e[SW-1:WIDTH+1];
        prev_r = e[WIDTH:1];
        @(posedge clock); #1;
        check("rdy_one_cycle", {63'd0, data_resultRDY}, 64'd0);
        check("hold_r_after_done", {32'd0, data_remainder}, {32'd0, prev_r});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int sel;
        int seen;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;

        reset_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        prev_q  = '0;
        prev_r  = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_rdy", {63'd0, data_resultRDY}, 64'd0);
        check("rst_exc", {63'd0, data_exception}, 64'd0);
        check("rst_q", {32'd0, data_quotient}, 64'd0);
        check("rst_r", {32'd0, data_remainder}, 64'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Directed cases, including start-while-busy followed by a back-to-back start.
        run_div(32'd100, 32'd7, 0);
        run_div(32'hFFFF_FF9C, 32'd7, 0);
        run_div(32'h1234, 32'd0, 0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_div(32'd100, 32'd7, 10);
        run_div(32'd50, 32'd5, 0);
        run_div(32'd0, 32'd1, 0);
        run_div(32'hFFFF_FFFF, 32'd1, 0);
        run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_div(32'd5, 32'd7, 0);

        // Reset in the middle of RUN, with start held high on the reset edge.
        start = 1'b1; a = 32'd100; b = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (14) @(posedge clock);
        #1;
        reset_n = 1'b0;
        start   = 1'b1;
        @(posedge clock); #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_rdy", {63'd0, data_resultRDY}, 64'd0);
        check("midrst_q", {32'd0, data_quotient}, 64'd0);
        check("midrst_r", {32'd0, data_remainder}, 64'd0);
        check("midrst_exc", {63'd0, data_exception}, 64'd0);
        reset_n = 1'b1;
        start   = 1'b0;
        seen    = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (data_resultRDY || busy) seen++;
        end
        check("no_activity_after_reset", 64'(seen), 64'd0);
        prev_q = '0;
        prev_r = '0;
        run_div(32'd1000, 32'd33, 0);

        // Random operands, biased toward tiny divisors (including zero) and small ones.
        repeat (25) begin
            x   = $urandom;
            sel = $urandom_range(0, 3);
            if (sel == 0)      y = $urandom_range(0, 3);
            else if (sel == 1) y = $urandom_range(1, 255);
            else               y = $urandom;
            run_div(x, y, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; only 32 is supported.
REQ-002 SHALL have port clock, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin a division; sampled on a rising edge.
REQ-005 SHALL have port data_operandA, input, WIDTH, dividend; captured when start is accepted.
REQ-006 SHALL have port data_operandB, input, WIDTH, divisor; captured when start is accepted.
REQ-007 SHALL have port busy, output, 1, high while a division is in progress.
REQ-008 SHALL have port data_quotient, output, WIDTH, quotient; valid while data_resultRDY is high.
REQ-009 SHALL have port data_remainder, output, WIDTH, remainder; valid while data_resultRDY is high.
REQ-010 SHALL have port data_exception, output, 1, divide-by-zero or overflow; valid while data_resultRDY is high.
REQ-011 SHALL have port data_resultRDY, output, 1, one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 In IDLE, start=1 SHALL be accepted: operands are captured, iteration counter is cleared, and the FSM goes to RUN (busy=1 from the next cycle).
REQ-014 RUN SHALL perform one restoring shift-subtract step per cycle, MSB first, using a WIDTH+1-bit partial remainder; a non-negative trial difference sets the quotient bit and replaces the remainder.
REQ-015 After exactly WIDTH RUN cycles, the FSM SHALL go to DONE.
REQ-016 DONE SHALL last exactly one cycle, with data_resultRDY=1 and busy=0, then return to IDLE.
REQ-017 Latency: data_resultRDY SHALL go high after the 33rd rising edge following the edge that accepted start.
REQ-018 Outputs data_quotient, data_remainder and data_exception SHALL hold their last value until the next DONE.
REQ-019 start asserted during RUN or DONE SHALL be ignored; no queuing.
REQ-020 start asserted in the IDLE cycle immediately after DONE SHALL be accepted (back-to-back operation).
REQ-021 Divisor=0 SHALL skip RUN and go to DONE on the next edge with quotient=0, remainder=dividend and data_exception=1.
REQ-022 Otherwise data_exception SHALL be 0, except as given in REQ-028.
REQ-023 Operand changes after acceptance SHALL have no effect on the result.

Reset
REQ-024 reset_n=0 at a rising edge SHALL force IDLE, with busy=0, data_resultRDY=0, data_exception=0, data_quotient=0, data_remainder=0 and counter=0.
REQ-025 Reset during RUN SHALL abort the operation; no data_resultRDY is produced for it.
REQ-026 When reset_n=0 and start=1 on the same edge, reset SHALL win and start SHALL be dropped.

Configuration
REQ-027 Macro DIV_SIGNED_EN defined: operands are two's complement; the divider works on magnitudes; the quotient is negated when operand signs differ; the remainder takes the sign of the dividend.
REQ-028 With DIV_SIGNED_EN defined, 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000, remainder 0 and data_exception=1, with normal 33-edge latency.
REQ-029 Macro DIV_SIGNED_EN undefined: operands are unsigned, no sign logic is present, and REQ-028 does not apply.

Verification
REQ-030 Basic division: A=100, B=7, start pulse -> data_resultRDY high exactly 33 edges later with q=14, r=2, exc=0, busy high for cycles 1..32.
REQ-031 Signed division (DIV_SIGNED_EN): A=0xFFFFFF9C (-100), B=7 -> q=0xFFFFFFF2, r=0xFFFFFFFE, exc=0. Unsigned build, same operands -> q=0x24924916, r=0x2.
REQ-032 Divide by zero: A=0x1234, B=0 -> data_resultRDY one edge after acceptance with q=0, r=0x1234, exc=1.
REQ-033 Overflow (DIV_SIGNED_EN): A=0x80000000, B=0xFFFFFFFF -> q=0x80000000, r=0, exc=1 at 33 edges.
REQ-034 Start while busy: second start at cycle 10 with A=50, B=5 -> ignored; first result (100/7) delivered; the next start in the IDLE cycle after DONE gives q=10 33 edges later.
REQ-035 Reset mid-operation: reset_n=0 at cycle 15 of RUN -> all outputs 0, no data_resultRDY pulse, and a fresh start works normally afterward.
